decoder_sel_sequencer: RTL and testbench



---
 rtl/decoder_pkg.sv | 9 +
 rtl/dwell_timer.sv | 18 +
 rtl/decoder_sel_sequencer.sv | 100 ++++++++++
 tb/tb_decoder_sel_sequencer.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// decoder_pkg: shared widths, FSM state type and Gray helper for the decoder select sequencer.
package decoder_pkg;
  localparam int SEL_W = 3;
  localparam int NUM_CODES = 8;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic logic [SEL_W-1:0] bin2gray(input logic [SEL_W-1:0] b);
    return b ^ (b >> 1);
  endfunction
endpackage

// File: rtl/dwell_timer.sv
// dwell_timer: counts handshake ticks on the current code; expire marks the accepting tick.
module dwell_timer #(
  parameter int DWELL = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic tick,
  output logic expire
);
  logic [7:0] cnt_q;
  assign expire = tick & (cnt_q == 8'(DWELL - 1));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else if (clr || expire) cnt_q <= '0;
    else if (tick) cnt_q <= cnt_q + 8'd1;
  end
endmodule

// File: rtl/decoder_sel_sequencer.sv
// decoder_sel_sequencer: registered x/y/z select sweep source with valid/ready dwell.
// Define SEL_GRAY_EN to present the Gray encoding of the internal binary code on x/y/z.
module decoder_sel_sequencer
  import decoder_pkg::*;
#(
  parameter int DWELL      = 1,
  parameter bit CONTINUOUS = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       dir,
  input  logic       load,
  input  logic [2:0] load_val,
  input  logic       sel_ready,
  output logic       sel_valid,
  output logic       x,
  output logic       y,
  output logic       z,
  output logic       busy,
  output logic       done,
  output logic [7:0] sweep_cnt
);
  state_t           state_q;
  logic [SEL_W-1:0] code_q, sel_q, first_d, step_d;
  logic [3:0]       code_cnt_q;
  logic [7:0]       sweep_cnt_q;
  logic             dir_q, sel_valid_q, busy_q, done_q, accept, last;
`ifdef SEL_GRAY_EN
  function automatic logic [SEL_W-1:0] enc(input logic [SEL_W-1:0] b);
    return bin2gray(b);
  endfunction
`else
  function automatic logic [SEL_W-1:0] enc(input logic [SEL_W-1:0] b);
    return b;
  endfunction
`endif
  dwell_timer #(.DWELL(DWELL)) u_dwell (
    .clk   (clk),
    .rst   (rst),
    .clr   (state_q != RUN || stop),
    .tick  (sel_valid_q & sel_ready),
    .expire(accept)
  );
  assign first_d = load ? load_val : (dir ? SEL_W'(NUM_CODES - 1) : '0);
  assign step_d  = dir_q ? code_q - 1'b1 : code_q + 1'b1;
  assign last    = code_cnt_q == 4'(NUM_CODES - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      code_q      <= '0;
      sel_q       <= '0;
      code_cnt_q  <= '0;
      sweep_cnt_q <= '0;
      dir_q       <= 1'b0;
      sel_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start && !stop) begin
          state_q     <= RUN;
          busy_q      <= 1'b1;
          sel_valid_q <= 1'b1;
          dir_q       <= dir;
          code_q      <= first_d;
          sel_q       <= enc(first_d);
          code_cnt_q  <= '0;
        end
        RUN: if (stop) begin
          state_q     <= IDLE;
          busy_q      <= 1'b0;
          sel_valid_q <= 1'b0;
        end else if (accept) begin
          code_cnt_q <= last ? '0 : code_cnt_q + 4'd1;
          if (last && sweep_cnt_q != 8'hff) sweep_cnt_q <= sweep_cnt_q + 8'd1;
          // a single sweep keeps its last code visible through DONE
          if (last && !CONTINUOUS) begin
            state_q     <= DONE;
            busy_q      <= 1'b0;
            sel_valid_q <= 1'b0;
            done_q      <= 1'b1;
          end else begin
            code_q <= step_d;
            sel_q  <= enc(step_d);
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign {x, y, z}  = sel_q;
  assign sel_valid  = sel_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign sweep_cnt  = sweep_cnt_q;
endmodule

// File: tb/tb_decoder_sel_sequencer.sv
// tb_decoder_sel_sequencer: directed sweeps on three configurations with an accepted-code scoreboard.
module tb_decoder_sel_sequencer;
  logic       clk = 1'b0;
  logic       rst, dir, load, rdy;
  logic [2:0] load_val, st, sp;
  logic [2:0] sv, xo, yo, zo, bz, dn;
  logic [7:0] sc [3];
  logic [4:0] exp_q[$];
  logic [2:0] gray_t [8] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};
  int         cmp = 0, err = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : dut
    decoder_sel_sequencer #(.DWELL(g == 1 ? 3 : 1), .CONTINUOUS(g == 2)) u (
      .clk(clk), .rst(rst), .start(st[g]), .stop(sp[g]), .dir(dir), .load(load),
      .load_val(load_val), .sel_ready(rdy), .sel_valid(sv[g]), .x(xo[g]), .y(yo[g]),
      .z(zo[g]), .busy(bz[g]), .done(dn[g]), .sweep_cnt(sc[g])
    );
  end
  function automatic logic [2:0] enc(input logic [2:0] b);
`ifdef SEL_GRAY_EN
    return gray_t[b];
`else
    return b;
`endif
  endfunction
  function automatic logic [2:0] code(input int g);
    return {xo[g], yo[g], zo[g]};
  endfunction
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    cmp++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic push(input int g, input logic [2:0] c);
    exp_q.push_back({2'(g), enc(c)});
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  for (genvar g = 0; g < 3; g++) begin : mon
    localparam int DW = (g == 1) ? 3 : 1;
    int         dc;
    logic       pv, pacc;
    logic [2:0] pc;
    logic [4:0] item;
    always @(negedge clk) begin
      if (rst) begin
        dc = 0;
        pv = 1'b0;
        pacc = 1'b0;
      end else begin
        if (pv && sv[g] && !pacc) chk("hold", 16'(code(g)), 16'(pc));
        pacc = 1'b0;
        if (sv[g] && rdy) begin
          if (dc == DW - 1) begin
            item = exp_q.size() > 0 ? exp_q.pop_front() : 5'h1f;
            chk("accept", 16'({2'(g), code(g)}), 16'(item));
            pacc = 1'b1;
            dc = 0;
          end else dc++;
        end else if (!sv[g]) dc = 0;
        pv = sv[g];
        pc = code(g);
      end
    end
  end
  initial begin
    int n;
    rst = 1'b1; dir = 1'b0; load = 1'b0; load_val = '0; rdy = 1'b0; st = '0; sp = '0;
    tick(2);
    for (int g = 0; g < 3; g++) begin
      chk("rst_out", 16'({sv[g], bz[g], dn[g], code(g)}), 16'd0);
      chk("rst_cnt", 16'(sc[g]), 16'd0);
    end
    rst = 1'b0;
    tick(1);
    // single up sweep, dwell 1
    rdy = 1'b1;
    for (int i = 0; i < 8; i++) push(0, 3'(i));
    st[0] = 1'b1;
    tick(1);
    st[0] = 1'b0;
    chk("t1_first", 16'({bz[0], sv[0], code(0)}), 16'({2'b11, enc(3'd0)}));
    tick(8);
    chk("t1_done", 16'({dn[0], sv[0], bz[0]}), 16'b100);
    chk("t1_sweep", 16'(sc[0]), 16'd1);
    chk("t1_last", 16'(code(0)), 16'(enc(3'd7)));
    tick(1);
    chk("t1_pulse", 16'(dn[0]), 16'd0);
    // down sweep, dwell 3, toggling ready
    dir = 1'b1;
    for (int i = 0; i < 8; i++) push(1, 3'(7 - i));
    st[1] = 1'b1;
    tick(1);
    st[1] = 1'b0;
    chk("t2_first", 16'(code(1)), 16'(enc(3'd7)));
    n = 0;
    while (!dn[1] && n < 200) begin
      rdy = ~rdy;
      tick(1);
      n++;
    end
    chk("t2_done", 16'(dn[1]), 16'd1);
    chk("t2_sweep", 16'(sc[1]), 16'd1);
    chk("t2_drain", 16'(exp_q.size()), 16'd0);
    rdy = 1'b1;
    tick(1);
    // loaded start code
    dir = 1'b0; load = 1'b1; load_val = 3'd5;
    for (int i = 0; i < 8; i++) push(0, 3'(5 + i));
    st[0] = 1'b1;
    tick(1);
    st[0] = 1'b0; load = 1'b0; load_val = 3'd0;
    chk("t3_first", 16'(code(0)), 16'(enc(3'd5)));
    n = 0;
    while (!dn[0] && n < 50) begin
      tick(1);
      n++;
    end
    chk("t3_done", 16'(dn[0]), 16'd1);
    chk("t3_sweep", 16'(sc[0]), 16'd2);
    chk("t3_last", 16'(code(0)), 16'(enc(3'd4)));
    chk("t3_drain", 16'(exp_q.size()), 16'd0);
    tick(1);
    // continuous: three sweeps without gaps, then stop
    for (int i = 0; i < 24; i++) push(2, 3'(i));
    st[2] = 1'b1;
    tick(1);
    st[2] = 1'b0;
    for (int i = 0; i < 24; i++) begin
      chk("t4_run", 16'({dn[2], sv[2]}), 16'b01);
      tick(1);
    end
    chk("t4_drain", 16'(exp_q.size()), 16'd0);
    chk("t4_sweep", 16'(sc[2]), 16'd3);
    chk("t4_wrap", 16'({dn[2], code(2)}), 16'(enc(3'd0)));
    rdy = 1'b0; sp[2] = 1'b1;
    tick(1);
    sp[2] = 1'b0;
    chk("t4_stop", 16'({sv[2], bz[2], dn[2]}), 16'd0);
    chk("t4_stop_cnt", 16'(sc[2]), 16'd3);
    chk("t4_stop_hold", 16'(code(2)), 16'(enc(3'd0)));
    rdy = 1'b1;
    // start and stop together in IDLE
    st[0] = 1'b1; sp[0] = 1'b1;
    tick(1);
    st[0] = 1'b0; sp[0] = 1'b0;
    chk("t5_stop_wins", 16'({bz[0], sv[0]}), 16'd0);
    // asynchronous reset mid-sweep
    for (int i = 0; i < 4; i++) push(0, 3'(i));
    st[0] = 1'b1;
    tick(1);
    st[0] = 1'b0;
    tick(4);
    chk("t5_code4", 16'({sv[0], code(0)}), 16'({1'b1, enc(3'd4)}));
    #1 rst = 1'b1;
    #1;
    chk("t5_rst_out", 16'({sv[0], bz[0], dn[0], code(0)}), 16'd0);
    chk("t5_rst_cnt", 16'(sc[0]), 16'd0);
    chk("t5_drain", 16'(exp_q.size()), 16'd0);
    tick(1);
    rst = 1'b0;
    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
